uart_cmd_ctrl: RTL and testbench

// - Byte-command processor between uart_rx and uart_tx. Drives a parametrised LED/GPIO bank.
// - Decodes 2-bit opcodes, queues response bytes in a TX FIFO, and paces uart_tx with a send/busy FSM.
// - Generalises the single-nibble LED echo path: wider LED bank, nibble-addressed write/read,

---
 rtl/uart_cmd_pkg.sv | 22 ++
 rtl/uart_cmd_ctrl_fifo.sv | 55 +++++
 rtl/uart_cmd_ctrl.sv | 167 ++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_ctrl shared types.
// Opcodes, TX FSM states, constants.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    OP_ECHO,
    OP_WRITE,
    OP_READ,
    OP_CLEAR
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_e;

  localparam logic [7:0] ACK_CLEAR = 8'hC0;
  localparam int BUSY_TIMEOUT = 2;

endpackage

// File: rtl/uart_cmd_ctrl_fifo.sv
// Response FIFO, first-word-fall-through.
// A push into a full FIFO succeeds only with a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             wr_en;
  logic             rd_en;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_q];
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= din;
  end

  // Pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Byte command processor between uart_rx and uart_tx.
// Drives an LED bank and queues response bytes.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         LED_W       = 8,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] ECHO_OFFSET = 8'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_send,
  output logic [LED_W-1:0] leds,
  output logic             overflow,
  output logic             cmd_err
);

  localparam int NIB = LED_W / 4;
  localparam logic [2:0] NIB_L = 3'(NIB);
  localparam logic [1:0] TO_M1 = 2'(BUSY_TIMEOUT - 1);

  logic             rx_valid_q;
  logic [LED_W-1:0] leds_q;
  logic [LED_W-1:0] leds_d;
  logic             err_q;
  logic             err_d;
  logic             ovf_q;
  tx_state_e        state_q;
  logic [1:0]       cnt_q;
  logic [7:0]       tx_data_q;
  logic             tx_send_q;

  logic       accept;
  opcode_e    op;
  logic [1:0] widx;
  logic [1:0] ridx;
  logic [3:0] rnib;
  logic       push;
  logic       pop;
  logic [7:0] rsp;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

  assign accept = rx_valid && !rx_valid_q;
  assign op     = opcode_e'(rx_data[7:6]);
  assign widx   = rx_data[5:4];
  assign ridx   = rx_data[1:0];
  assign pop    = (state_q == IDLE) && !fifo_empty && !tx_busy;

  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign leds     = leds_q;
  assign overflow = ovf_q;
  assign cmd_err  = err_q;

  // Decode an accepted byte into an LED update and a response.
  always_comb begin
    leds_d = leds_q;
    err_d  = 1'b0;
    push   = 1'b0;
    rsp    = '0;
    rnib   = '0;
    for (int i = 0; i < NIB; i++) begin
      if (ridx == i[1:0]) rnib = leds_q[i*4 +: 4];
    end
    if (accept) begin
      unique case (op)
        OP_ECHO: begin
          push = 1'b1;
          rsp  = rx_data + ECHO_OFFSET;
        end
        OP_WRITE: begin
          if ({1'b0, widx} < NIB_L) begin
            for (int i = 0; i < NIB; i++) begin
              if (widx == i[1:0]) leds_d[i*4 +: 4] = rx_data[3:0];
            end
            push = 1'b1;
            rsp  = {2'b01, widx, rx_data[3:0]};
          end else begin
            err_d = 1'b1;
          end
        end
        OP_READ: begin
          if ({1'b0, ridx} < NIB_L) begin
            push = 1'b1;
            rsp  = {2'b10, ridx, rnib};
          end else begin
            err_d = 1'b1;
          end
        end
        OP_CLEAR: begin
          leds_d = '0;
          push   = 1'b1;
          rsp    = ACK_CLEAR;
        end
      endcase
    end
  end

  // Edge detect, LED bank, error pulse, sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      leds_q     <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      leds_q     <= leds_d;
      err_q      <= err_d;
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  // TX pacing: one send per uart_tx frame.
  // The send cycle counts toward the busy timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q   <= SEND;
            tx_data_q <= fifo_dout;
            tx_send_q <= 1'b1;
          end
        end
        SEND: begin
          tx_send_q <= 1'b0;
          cnt_q     <= 2'd1;
          state_q   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy || cnt_q >= TO_M1) state_q <= WAIT_DONE;
          else cnt_q <= cnt_q + 2'd1;
        end
        WAIT_DONE: begin
          if (!tx_busy) state_q <= IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (rsp),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl.
// Random commands against a nibble-array model.
module tb_uart_cmd_ctrl;

  localparam int LED_W = 8;
  localparam int NIB = LED_W / 4;
  localparam int DEPTH = 4;
  localparam logic [7:0] OFS = 8'd1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             tx_busy = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_send;
  logic [LED_W-1:0] leds;
  logic             overflow;
  logic             cmd_err;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] exp_arr[$];
  int         rd_idx = 0;
  int         n_sends = 0;
  int         busy_cnt = 0;
  int         last_cyc = 0;
  int         prev_cyc = 0;
  logic [7:0] last_tx = 8'h00;
  bit         force_busy = 0;
  bit         no_busy = 0;
  logic [3:0] m_nib [NIB];

  uart_cmd_ctrl #(
    .LED_W(LED_W),
    .FIFO_DEPTH(DEPTH),
    .ECHO_OFFSET(OFS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_busy (tx_busy),
    .tx_data (tx_data),
    .tx_send (tx_send),
    .leds    (leds),
    .overflow(overflow),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LED_W-1:0] model_leds();
    logic [LED_W-1:0] r;
    r = '0;
    for (int i = 0; i < NIB; i++)
      r = r + (LED_W'(m_nib[i]) << (4 * i));
    return r;
  endfunction

  function automatic void model(input logic [7:0] b,
                                output logic err,
                                output logic psh,
                                output logic [7:0] rsp);
    int idx;
    err = 1'b0;
    psh = 1'b0;
    rsp = 8'h00;
    case (b[7:6])
      2'd0: begin
        psh = 1'b1;
        rsp = 8'((int'(b) + int'(OFS)) % 256);
      end
      2'd1: begin
        idx = int'(b[5:4]);
        if (idx < NIB) begin
          m_nib[idx] = b[3:0];
          psh = 1'b1;
          rsp = 8'(64 + idx * 16 + int'(b[3:0]));
        end else err = 1'b1;
      end
      2'd2: begin
        idx = int'(b[1:0]);
        if (idx < NIB) begin
          psh = 1'b1;
          rsp = 8'(128 + idx * 16 + int'(m_nib[idx]));
        end else err = 1'b1;
      end
      default: begin
        for (int i = 0; i < NIB; i++) m_nib[i] = 4'h0;
        psh = 1'b1;
        rsp = 8'hC0;
      end
    endcase
  endfunction

  // uart_tx stand-in: busy for 10 cycles after each send.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      rd_idx = exp_arr.size();
    end else if (tx_send) begin
      check("tx_idle", 32'(tx_busy), 0);
      check("tx_expected", 32'(rd_idx < exp_arr.size()), 1);
      if (rd_idx < exp_arr.size()) begin
        check("tx_byte", 32'(tx_data), 32'(exp_arr[rd_idx]));
        rd_idx++;
      end
      last_tx = tx_data;
      n_sends++;
      prev_cyc = last_cyc;
      last_cyc = cyc;
      if (!no_busy) busy_cnt = 10;
    end else begin
      if (tx_busy) check("tx_hold", 32'(tx_data), 32'(last_tx));
      if (busy_cnt > 0) busy_cnt--;
    end
    tx_busy = force_busy || (busy_cnt > 0);
  end

  task automatic send_cmd(input logic [7:0] b, input int hold);
    logic err;
    logic psh;
    logic [7:0] rsp;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    model(b, err, psh, rsp);
    if (psh) exp_arr.push_back(rsp);
    @(negedge clk);
    check("leds", 32'(leds), 32'(model_leds()));
    check("cmd_err", 32'(cmd_err), 32'(err));
    if (hold >= 2) begin
      @(negedge clk);
      check("cmd_err_pulse", 32'(cmd_err), 0);
      repeat (hold - 2) @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((rd_idx != exp_arr.size() || tx_busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(rd_idx == exp_arr.size()), 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [7:0] b;
    for (int i = 0; i < NIB; i++) m_nib[i] = 4'h0;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_leds", 32'(leds), 0);
    check("rst_send", 32'(tx_send), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_err", 32'(cmd_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    s0 = n_sends;
    send_cmd(8'h05, 1);
    send_cmd(8'h3F, 1);
    send_cmd(8'h3F, 1);
    drain();
    check("echo_sends", 32'(n_sends - s0), 3);

    send_cmd(8'h4A, 1);
    send_cmd(8'h53, 1);
    send_cmd(8'h81, 1);
    send_cmd(8'h60, 1);
    send_cmd(8'hC0, 1);
    drain();

    s0 = n_sends;
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom_range(0, 63));
      send_cmd(b, 1);
      if (i == DEPTH - 1) check("ovf_pre", 32'(overflow), 0);
      if (i == DEPTH) begin
        void'(exp_arr.pop_back());
        check("ovf_set", 32'(overflow), 1);
      end
    end
    repeat (4) @(negedge clk);
    check("no_send_busy", 32'(n_sends - s0), 0);
    force_busy = 1'b0;
    drain();
    check("ovf_sends", 32'(n_sends - s0), DEPTH);
    check("ovf_sticky", 32'(overflow), 1);

    no_busy = 1'b1;
    s0 = n_sends;
    send_cmd(8'($urandom_range(0, 63)), 20);
    repeat (10) @(negedge clk);
    check("held_once", 32'(n_sends - s0), 1);
    send_cmd(8'($urandom_range(0, 63)), 1);
    send_cmd(8'($urandom_range(0, 63)), 1);
    repeat (15) @(negedge clk);
    check("guard_sends", 32'(n_sends - s0), 3);
    check("guard_gap", 32'((last_cyc - prev_cyc) <= 4), 1);
    drain();
    no_busy = 1'b0;

    for (int k = 0; k < 40; k++) begin
      send_cmd(8'($urandom_range(0, 255)), $urandom_range(1, 3));
      repeat ($urandom_range(12, 18)) @(negedge clk);
    end
    drain();

    send_cmd(8'h45, 1);
    send_cmd(8'($urandom_range(0, 63)), 1);
    send_cmd(8'($urandom_range(0, 63)), 1);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_leds", 32'(leds), 0);
    check("arst_send", 32'(tx_send), 0);
    check("arst_data", 32'(tx_data), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_err", 32'(cmd_err), 0);
    for (int i = 0; i < NIB; i++) m_nib[i] = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = n_sends;
    repeat (30) @(negedge clk);
    check("post_rst_quiet", 32'(n_sends - s0), 0);
    send_cmd(8'h12, 1);
    drain();
    check("post_rst_send", 32'(n_sends - s0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
